snowbro2_gfx_fetch: RTL and testbench



---
 rtl/snowbro2_gfx_fetch.sv | 184 ++++++++++++++++++
 tb/tb_snowbro2_gfx_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/snowbro2_gfx_fetch.sv
// snowbro2_gfx_fetch
//   Fetch sequencer between one 32-bit graphics ROM client and one 16-bit
//   SDRAM bank. A 32-bit word request becomes two sequential 16-bit reads
//   (low half at even address, high half at odd address). The last fetched
//   word is held in a one-entry tag cache so repeated addresses complete
//   without SDRAM traffic.
//
// Ports
//   CLK        system clock (single domain)
//   RESET      asynchronous, active-high reset
//   CS         client request, held while ADDR is wanted
//   ADDR       client 32-bit word address
//   OK         DOUT valid for the current ADDR (registered)
//   DOUT       cached word {high half, low half}
//   BA_ADDR    SDRAM 16-bit word address (registered)
//   BA_RD      SDRAM read request, held until BA_ACK
//   BA_ACK     request accepted (one-cycle pulse)
//   BA_RDY     DATA_READ valid (one-cycle pulse)
//   DATA_READ  SDRAM read data
//   BUSY       an SDRAM access is in flight
module snowbro2_gfx_fetch #(
    parameter logic [21:0] BASE = 22'h000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS,
    input  logic [20:0] ADDR,
    output logic        OK,
    output logic [31:0] DOUT,
    output logic [21:0] BA_ADDR,
    output logic        BA_RD,
    input  logic        BA_ACK,
    input  logic        BA_RDY,
    input  logic [15:0] DATA_READ,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_LO   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_RD_HI   = 3'd3,
        S_WAIT_HI = 3'd4,
        S_FILL    = 3'd5
    } state_t;

    state_t      state_q, state_d;

    logic [20:0] pend_q, pend_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] hi_q, hi_d;
    logic [20:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        ok_q, ok_d;
    logic [21:0] ba_addr_q, ba_addr_d;
    logic        ba_rd_q, ba_rd_d;

    // FSM control strobes
    logic        hit;
    logic        start_lo;
    logic        start_hi;
    logic        cap_hi;
    logic        ack_take;
    logic        fill;

    // Cache hit uses the registered cache contents; a FILL becomes visible
    // to the hit compare one cycle later, which is what makes OK land one
    // cycle after the FILL state.
    assign hit = CS & valid_q & (ADDR == tag_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (CS && !hit) state_d = S_RD_LO;
            S_RD_LO:   if (BA_ACK)     state_d = S_WAIT_LO;
            S_WAIT_LO: if (BA_RDY)     state_d = S_RD_HI;
            S_RD_HI:   if (BA_ACK)     state_d = S_WAIT_HI;
            S_WAIT_HI: if (BA_RDY)     state_d = S_FILL;
            S_FILL:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    // RDY is only honoured in WAIT_x and ACK only in RD_x, so stray strobes
    // in any other state fall through without effect.
    always_comb begin
        start_lo = 1'b0;
        start_hi = 1'b0;
        cap_hi   = 1'b0;
        ack_take = 1'b0;
        fill     = 1'b0;
        BUSY     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:    start_lo = CS & ~hit;
            S_RD_LO:   ack_take = BA_ACK;
            S_WAIT_LO: start_hi = BA_RDY;
            S_RD_HI:   ack_take = BA_ACK;
            S_WAIT_HI: cap_hi   = BA_RDY;
            S_FILL:    fill     = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        pend_d    = pend_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        data_d    = data_q;
        ba_addr_d = ba_addr_q;
        ba_rd_d   = ba_rd_q;
        ok_d      = hit;

        // Address is computed on the transition into RD_x so BA_ADDR is
        // already stable on the first BA_RD cycle. Sum wraps modulo 2^22.
        if (start_lo) begin
            pend_d    = ADDR;
            ba_addr_d = BASE + {ADDR, 1'b0};
            ba_rd_d   = 1'b1;
        end
        if (start_hi) begin
            lo_d      = DATA_READ;
            ba_addr_d = BASE + {pend_q, 1'b1};
            ba_rd_d   = 1'b1;
        end
        if (ack_take) begin
            ba_rd_d = 1'b0;
        end
        if (cap_hi) begin
            hi_d = DATA_READ;
        end
        if (fill) begin
            tag_d   = pend_q;
            data_d  = {hi_q, lo_q};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ok_q      <= 1'b0;
            ba_addr_q <= BASE;
            ba_rd_q   <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
        end
    end

    // DOUT is the cache data register itself: it only changes at FILL and
    // never shows a half-assembled word.
    assign OK      = ok_q;
    assign DOUT    = data_q;
    assign BA_ADDR = ba_addr_q;
    assign BA_RD   = ba_rd_q;

endmodule

// File: tb/tb_snowbro2_gfx_fetch.sv
module tb_snowbro2_gfx_fetch;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS;
    logic [20:0] ADDR;
    logic        BA_ACK;
    logic        BA_RDY;
    logic [15:0] DATA_READ;

    logic        OK,      OK_b;
    logic [31:0] DOUT,    DOUT_b;
    logic [21:0] BA_ADDR, BA_ADDR_b;
    logic        BA_RD,   BA_RD_b;
    logic        BUSY,    BUSY_b;

    int ncomp = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    snowbro2_gfx_fetch #(.BASE(22'h100000)) dut (
        .CLK(CLK), .RESET(RESET), .CS(CS), .ADDR(ADDR),
        .OK(OK), .DOUT(DOUT), .BA_ADDR(BA_ADDR), .BA_RD(BA_RD),
        .BA_ACK(BA_ACK), .BA_RDY(BA_RDY), .DATA_READ(DATA_READ), .BUSY(BUSY)
    );

    // Second instance sees identical stimulus; used for the address wrap.
    snowbro2_gfx_fetch #(.BASE(22'h3FFFFE)) dut_b (
        .CLK(CLK), .RESET(RESET), .CS(CS), .ADDR(ADDR),
        .OK(OK_b), .DOUT(DOUT_b), .BA_ADDR(BA_ADDR_b), .BA_RD(BA_RD_b),
        .BA_ACK(BA_ACK), .BA_RDY(BA_RDY), .DATA_READ(DATA_READ), .BUSY(BUSY_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Serve one 16-bit read: ACK in the first BA_RD cycle, RDY 3 cycles later.
    // Optionally change ADDR in the cycle after ACK (WAIT state).
    task automatic serve(input string tag, input logic [21:0] ea, input logic [21:0] eb,
                         input logic [15:0] d, input bit chg, input logic [20:0] na);
        int k;
        k = 0;
        while (BA_RD !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rd"}, 32'(BA_RD), 32'd1);
        if (BA_RD === 1'b1) begin
            chk({tag, "_addr"},   32'(BA_ADDR),   32'(ea));
            chk({tag, "_addr_b"}, 32'(BA_ADDR_b), 32'(eb));
            BA_ACK = 1'b1;
            tick();
            BA_ACK = 1'b0;
            chk({tag, "_rd_drop"}, 32'(BA_RD), 32'd0);
            if (chg) ADDR = na;
            tick();
            tick();
            BA_RDY    = 1'b1;
            DATA_READ = d;
            tick();
            BA_RDY    = 1'b0;
            DATA_READ = 16'h0000;
        end
    endtask

    initial begin
        RESET = 1'b1; CS = 1'b0; ADDR = '0;
        BA_ACK = 1'b0; BA_RDY = 1'b0; DATA_READ = '0;
        tick();
        tick();
        // reset state
        chk("rst_ok",     32'(OK),        32'd0);
        chk("rst_dout",   DOUT,           32'h0);
        chk("rst_rd",     32'(BA_RD),     32'd0);
        chk("rst_addr",   32'(BA_ADDR),   32'h100000);
        chk("rst_busy",   32'(BUSY),      32'd0);
        chk("rst_addr_b", 32'(BA_ADDR_b), 32'h3FFFFE);
        chk("rst_rd_b",   32'(BA_RD_b),   32'd0);
        chk("rst_busy_b", 32'(BUSY_b),    32'd0);
        RESET = 1'b0;
        tick();

        // cold miss, cycle 0 = request presented
        CS = 1'b1; ADDR = 21'h000004;
        tick();
        chk("cold_rd_c1",   32'(BA_RD), 32'd1);
        chk("cold_busy_c1", 32'(BUSY),  32'd1);
        serve("cold_lo", 22'h100008, 22'h000006, 16'h1234, 1'b0, '0);
        serve("cold_hi", 22'h100009, 22'h000007, 16'hABCD, 1'b0, '0);
        chk("cold_ok_c9", 32'(OK), 32'd0);
        tick();
        chk("cold_ok_c10", 32'(OK), 32'd0);
        tick();
        chk("cold_ok_c11",   32'(OK),   32'd1);
        chk("cold_dout_c11", DOUT,      32'hABCD1234);
        chk("cold_busy_c11", 32'(BUSY), 32'd0);

        // repeat hit
        CS = 1'b0;
        tick();
        chk("hit_cs_off", 32'(OK), 32'd0);
        CS = 1'b1; ADDR = 21'h000004;
        tick();
        chk("hit_ok",   32'(OK),    32'd1);
        chk("hit_dout", DOUT,       32'hABCD1234);
        chk("hit_rd",   32'(BA_RD), 32'd0);
        tick();
        chk("hit_rd2",  32'(BA_RD), 32'd0);
        chk("hit_busy", 32'(BUSY),  32'd0);
        chk("hit_ok2",  32'(OK),    32'd1);

        // evict with another address
        ADDR = 21'h000006;
        serve("ev_lo", 22'h10000C, 22'h00000A, 16'h5555, 1'b0, '0);
        serve("ev_hi", 22'h10000D, 22'h00000B, 16'h6666, 1'b0, '0);
        tick();
        tick();
        chk("ev_ok",   32'(OK), 32'd1);
        chk("ev_dout", DOUT,    32'h66665555);

        // address change 0x4 -> 0x5 during WAIT_LO
        ADDR = 21'h000004;
        serve("chg_lo", 22'h100008, 22'h000006, 16'h1111, 1'b1, 21'h000005);
        serve("chg_hi", 22'h100009, 22'h000007, 16'h2222, 1'b0, '0);
        chk("chg_ok_fill", 32'(OK), 32'd0);
        tick();
        chk("chg_ok_after",  32'(OK), 32'd0);
        chk("chg_dout_old",  DOUT,    32'h22221111);
        serve("chg2_lo", 22'h10000A, 22'h000008, 16'h3333, 1'b0, '0);
        serve("chg2_hi", 22'h10000B, 22'h000009, 16'h4444, 1'b0, '0);
        chk("chg2_ok_fill", 32'(OK), 32'd0);
        tick();
        chk("chg2_ok_c10", 32'(OK), 32'd0);
        tick();
        chk("chg2_ok",   32'(OK), 32'd1);
        chk("chg2_dout", DOUT,    32'h44443333);

        // spurious RDY in IDLE
        CS = 1'b0;
        tick();
        BA_RDY = 1'b1; DATA_READ = 16'hDEAD;
        tick();
        BA_RDY = 1'b0; DATA_READ = 16'h0000;
        chk("sp_idle_busy", 32'(BUSY),  32'd0);
        chk("sp_idle_rd",   32'(BA_RD), 32'd0);
        chk("sp_idle_dout", DOUT,       32'h44443333);
        // spurious RDY during RD_LO
        CS = 1'b1; ADDR = 21'h000010;
        tick();
        chk("sp_rdlo_rd", 32'(BA_RD), 32'd1);
        BA_RDY = 1'b1; DATA_READ = 16'hBEEF;
        tick();
        BA_RDY = 1'b0; DATA_READ = 16'h0000;
        chk("sp_rdlo_hold", 32'(BA_RD),   32'd1);
        chk("sp_rdlo_addr", 32'(BA_ADDR), 32'h100020);
        serve("sp_lo", 22'h100020, 22'h00001E, 16'h0A0B, 1'b0, '0);
        serve("sp_hi", 22'h100021, 22'h00001F, 16'h0C0D, 1'b0, '0);
        tick();
        tick();
        chk("sp_ok",   32'(OK), 32'd1);
        chk("sp_dout", DOUT,    32'h0C0D0A0B);

        // reset in the middle of WAIT_HI
        ADDR = 21'h000011;
        serve("rs_lo", 22'h100022, 22'h000020, 16'h9999, 1'b0, '0);
        chk("rs_hi_rd", 32'(BA_RD), 32'd1);
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        chk("rs_busy_pre", 32'(BUSY), 32'd1);
        tick();
        RESET = 1'b1; ADDR = 21'h000010; CS = 1'b1;
        #1;
        chk("rs_rd",   32'(BA_RD),   32'd0);
        chk("rs_ok",   32'(OK),      32'd0);
        chk("rs_busy", 32'(BUSY),    32'd0);
        chk("rs_addr", 32'(BA_ADDR), 32'h100000);
        chk("rs_dout", DOUT,         32'h0);
        BA_RDY = 1'b1; DATA_READ = 16'h5A5A;
        tick();
        BA_RDY = 1'b0; DATA_READ = 16'h0000;
        chk("rs_hold_rd", 32'(BA_RD), 32'd0);
        chk("rs_hold_ok", 32'(OK),    32'd0);
        RESET = 1'b0;
        tick();
        chk("rs_rel_rd", 32'(BA_RD), 32'd1);
        serve("rs2_lo", 22'h100020, 22'h00001E, 16'h7777, 1'b0, '0);
        serve("rs2_hi", 22'h100021, 22'h00001F, 16'h8888, 1'b0, '0);
        tick();
        tick();
        chk("rs2_ok",   32'(OK), 32'd1);
        chk("rs2_dout", DOUT,    32'h88887777);

        // address wrap on the BASE=0x3FFFFE instance
        ADDR = 21'h000001;
        serve("wrap_lo", 22'h100002, 22'h000000, 16'h0001, 1'b0, '0);
        serve("wrap_hi", 22'h100003, 22'h000001, 16'h0002, 1'b0, '0);
        tick();
        tick();
        chk("wrap_ok",    32'(OK),   32'd1);
        chk("wrap_ok_b",  32'(OK_b), 32'd1);
        chk("wrap_dout_b", DOUT_b,   32'h00020001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
